// File: rtl/seg7_scan_if.sv
// Host-side bundle for the 7-segment scan controller: the value/dp/lzs
// write port and the frame, digit-enable and segment outputs.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                lzs;
    logic                load;
    logic                frame;
    logic [DIGITS-1:0]   an;
    logic [7:0]          seg;

    // Host side drives the display data and watches the scan outputs.
    modport master (
        output value, dp, lzs, load,
        input  frame, an, seg
    );

    // Scan controller side.
    modport slave (
        input  value, dp, lzs, load,
        output frame, an, seg
    );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One digit is enabled per slot of SCAN_DIV cycles; the first BLANK cycles
// of each slot keep every digit dark so the previous digit's pattern cannot
// ghost onto the next anode. Display data is double-buffered and only
// swapped on the last cycle of the final digit's slot, so a frame never
// shows a mix of old and new values.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_BLANK | cnt < BLANK: all anodes off, segments off
// ST_ON    | cnt >= BLANK: digit idx driven (or blanked by zero suppress)
//
// state_q tracks the (cnt_q, idx_q) pair, so it is updated from cnt_d.
// Outputs are registered from state_q/idx_q, one cycle behind the counters.
module seg7_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    seg7_scan_if.slave bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    localparam state_t RST_STATE = (BLANK > 0) ? ST_BLANK : ST_ON;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] stage_val_q, stage_val_d;
    logic [DIGITS-1:0]   stage_dp_q, stage_dp_d;
    logic [4*DIGITS-1:0] active_val_q, active_val_d;
    logic [DIGITS-1:0]   active_dp_q, active_dp_d;
    logic                frame_q, frame_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    state_t              state_q, state_d;

    logic                last_cyc;
    logic                boundary;
    logic                blank_next;
    logic [3:0]          nib;
    logic                upper_zero;
    logic                suppress;
    logic [7:0]          dec;

    // Hex to active-low {dp,g,f,e,d,c,b,a}; dp is left off here.
    function automatic logic [7:0] seg7dec(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Slot counter, digit index and the staging/active double buffer.
    always_comb begin
        last_cyc = (cnt_q == CNT_W'(SCAN_DIV - 1));
        boundary = last_cyc && (idx_q == IDX_W'(DIGITS - 1));

        cnt_d = last_cyc ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (last_cyc) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        stage_val_d = bus.load ? bus.value : stage_val_q;
        stage_dp_d  = bus.load ? bus.dp    : stage_dp_q;

        // Taking the post-load staging value lets a load on the boundary
        // cycle reach the display in the very next frame.
        active_val_d = boundary ? stage_val_d : active_val_q;
        active_dp_d  = boundary ? stage_dp_d  : active_dp_q;

        frame_d = boundary;
    end

    // Slot phase for the next (cnt, idx); with BLANK=0 there is no blank phase.
    if (BLANK == 0) begin : g_no_blank
        assign blank_next = 1'b0;
    end else begin : g_blank
        assign blank_next = (cnt_d < CNT_W'(BLANK));
    end

    // Next-state logic of the slot FSM.
    always_comb begin
        state_d = blank_next ? ST_BLANK : ST_ON;
    end

    // State register of the slot FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode: digit enable and segment pattern for the current slot.
    always_comb begin
        an_d       = '1;
        seg_d      = 8'hFF;
        nib        = active_val_q[4*idx_q +: 4];
        dec        = seg7dec(nib);
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if ((j >= int'(idx_q)) && (active_val_q[4*j +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        // Digit 0 is never suppressed so a zero value still shows "0".
        suppress = bus.lzs && (idx_q != '0) && upper_zero;

        if (state_q == ST_ON) begin
            if (suppress) begin
                if (active_dp_q[idx_q]) begin
                    an_d[idx_q] = 1'b0;
                    seg_d       = 8'h7F;
                end
            end else begin
                an_d[idx_q] = 1'b0;
                seg_d       = {~active_dp_q[idx_q], dec[6:0]};
            end
        end
    end

    // Counters, buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            stage_val_q  <= '0;
            stage_dp_q   <= '0;
            active_val_q <= '0;
            active_dp_q  <= '0;
            frame_q      <= 1'b0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stage_val_q  <= stage_val_d;
            stage_dp_q   <= stage_dp_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            frame_q      <= frame_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign bus.frame = frame_q;
    assign bus.an    = an_q;
    assign bus.seg   = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: a DIGITS=4/SCAN_DIV=8/BLANK=2 instance for
// the main sequence and a SCAN_DIV=2/BLANK=0 instance for the extremes.
module tb_seg7_scan;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seg7_scan_if #(.DIGITS(4)) b1 ();
    seg7_scan_if #(.DIGITS(4)) b2 ();

    seg7_scan #(.DIGITS(4), .SCAN_DIV(8), .BLANK(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    seg7_scan #(.DIGITS(4), .SCAN_DIV(2), .BLANK(0)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_seg [4];
    logic [3:0] exp_an  [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_frame(input int which);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            seen = (which == 1) ? b1.frame : b2.frame;
        end
        if (!seen) begin
            n_total++;
            $error("FAIL frame_timeout_dut%0d: observed no frame expected frame within 100 cycles", which);
        end
    endtask

    task automatic set_exp(input logic [7:0] s0, s1, s2, s3,
                           input logic [3:0] a0, a1, a2, a3);
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        exp_an[0]  = a0; exp_an[1]  = a1; exp_an[2]  = a2; exp_an[3]  = a3;
    endtask

    // t counts cycles since the frame pulse was seen; outputs then reflect
    // frame position t-1 (8-cycle slots, first 2 blank).
    task automatic step(input int t, input string tag);
        int p, d, c;
        logic [7:0] es;
        logic [3:0] ea;
        tick();
        p = t - 1;
        d = p / 8;
        c = p % 8;
        if (c < 2) begin
            es = 8'hFF;
            ea = 4'hF;
        end else begin
            es = exp_seg[d];
            ea = exp_an[d];
        end
        chk($sformatf("%s_an_t%0d", tag, t), {4'h0, b1.an}, {4'h0, ea});
        chk($sformatf("%s_seg_t%0d", tag, t), b1.seg, es);
        chk($sformatf("%s_frame_t%0d", tag, t), {7'd0, b1.frame}, {7'd0, (t == 32)});
    endtask

    task automatic scan_frame(input string tag);
        for (int t = 1; t <= 32; t++) step(t, tag);
    endtask

    task automatic load1(input logic [15:0] v, input logic [3:0] d);
        b1.value = v;
        b1.dp    = d;
        b1.load  = 1'b1;
        tick();
        b1.load  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        b1.value = 16'h0000;
        b1.dp    = 4'h0;
        b1.lzs   = 1'b0;
        b1.load  = 1'b0;
        b2.value = 16'hFFFF;
        b2.dp    = 4'h0;
        b2.lzs   = 1'b0;
        b2.load  = 1'b1;

        tick();
        tick();
        chk("rst_seg", b1.seg, 8'hFF);
        chk("rst_an", {4'h0, b1.an}, 8'h0F);
        chk("rst_frame", {7'd0, b1.frame}, 8'h00);
        chk("rst_an_x", {4'h0, b2.an}, 8'h0F);

        rst_n = 1'b1;
        tick();
        chk("rel_an_c1", {4'h0, b1.an}, 8'h0F);
        tick();
        chk("rel_an_c2", {4'h0, b1.an}, 8'h0F);
        tick();
        chk("rel_an_c3", {4'h0, b1.an}, 8'h0E);
        chk("rel_seg_c3", b1.seg, 8'hC0);

        load1(16'h12A0, 4'h0);
        wait_frame(1);
        set_exp(8'hC0, 8'h88, 8'hA4, 8'hF9, 4'hE, 4'hD, 4'hB, 4'h7);
        scan_frame("scan");

        b1.lzs = 1'b1;
        load1(16'h0050, 4'h0);
        wait_frame(1);
        set_exp(8'hC0, 8'h92, 8'hFF, 8'hFF, 4'hE, 4'hD, 4'hF, 4'hF);
        scan_frame("lzs50");

        load1(16'h0000, 4'h0);
        wait_frame(1);
        set_exp(8'hC0, 8'hFF, 8'hFF, 8'hFF, 4'hE, 4'hF, 4'hF, 4'hF);
        scan_frame("lzs0");

        load1(16'h0005, 4'b0010);
        wait_frame(1);
        set_exp(8'h92, 8'h7F, 8'hFF, 8'hFF, 4'hE, 4'hD, 4'hF, 4'hF);
        scan_frame("dp_lzs");

        b1.lzs = 1'b0;
        set_exp(8'h92, 8'h40, 8'hC0, 8'hC0, 4'hE, 4'hD, 4'hB, 4'h7);
        scan_frame("dp_nolzs");

        // Two mid-frame loads must not disturb the frame being shown.
        for (int t = 1; t <= 32; t++) begin
            if (t == 4) begin
                b1.value = 16'h1111; b1.dp = 4'h0; b1.load = 1'b1;
            end
            if (t == 5) b1.load = 1'b0;
            if (t == 6) begin
                b1.value = 16'h2222; b1.load = 1'b1;
            end
            if (t == 7) b1.load = 1'b0;
            step(t, "buf_hold");
        end

        // Last write wins; a load on the boundary cycle goes straight to active.
        set_exp(8'hA4, 8'hA4, 8'hA4, 8'hA4, 4'hE, 4'hD, 4'hB, 4'h7);
        for (int t = 1; t <= 32; t++) begin
            if (t == 32) begin
                b1.value = 16'h3333; b1.load = 1'b1;
            end
            step(t, "buf_last");
        end
        b1.load = 1'b0;
        set_exp(8'hB0, 8'hB0, 8'hB0, 8'hB0, 4'hE, 4'hD, 4'hB, 4'h7);
        scan_frame("bypass");

        wait_frame(2);
        for (int t = 1; t <= 8; t++) begin
            int d;
            logic [3:0] ea;
            tick();
            d  = (t - 1) / 2;
            ea = ~(4'b0001 << d);
            chk($sformatf("ext_an_t%0d", t), {4'h0, b2.an}, {4'h0, ea});
            chk($sformatf("ext_seg_t%0d", t), b2.seg, 8'h8E);
            chk($sformatf("ext_frame_t%0d", t), {7'd0, b2.frame}, {7'd0, (t == 8)});
        end

        // Reset during digit 2 ON must blank immediately.
        wait_frame(1);
        for (int t = 1; t <= 20; t++) tick();
        chk("mid_pre_an", {4'h0, b1.an}, 8'h0B);
        chk("mid_pre_seg", b1.seg, 8'hB0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_an", {4'h0, b1.an}, 8'h0F);
        chk("mid_rst_seg", b1.seg, 8'hFF);
        chk("mid_rst_frame", {7'd0, b1.frame}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_c1", {4'h0, b1.an}, 8'h0F);
        tick();
        chk("mid_rel_c2", {4'h0, b1.an}, 8'h0F);
        tick();
        chk("mid_rel_an_c3", {4'h0, b1.an}, 8'h0E);
        chk("mid_rel_seg_c3", b1.seg, 8'hC0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment display.
- Holds a double-buffered hex value and steps through one digit per slot, driving one digit enable at a time.
- Each digit's nibble goes through the team's seg7dec decoder: hex in, active-low {dp,g..a} out, bit7=dp, 4'h0→8'b1100_0000.
- Adds anti-ghost blanking at the start of each slot, leading-zero suppression and per-digit decimal points.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
SCAN_DIV, 50000, clock cycles per digit slot (>=2)
BLANK, 500, cycles at start of each slot with all digits off (0 <= BLANK < SCAN_DIV)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value  input  4*DIGITS  hex digits; value[3:0]=digit 0 (least significant)
dp  input  DIGITS  decimal point request per digit, 1=lit
lzs  input  1  leading-zero suppression enable (level, sampled live)
load  input  1  write strobe for value/dp
frame  output  1  one-cycle pulse when buffers swap (end of digit DIGITS-1 slot)
an  output  DIGITS  digit enables, active-low
seg  output  8  segment pattern, active-low, bit7=dp, bits6:0=g..a

Behaviour:
- Reset (async assert, sync release):
  - seg=8'hFF, an=all 1s, frame=0.
  - cnt=0, idx=0, staging=0, active=0 (value and dp).
  - Reset mid-slot blanks outputs immediately; the scan restarts at digit 0, cnt 0.
- Counters:
  - cnt counts 0..SCAN_DIV-1 each cycle.
  - At cnt==SCAN_DIV-1: cnt→0 and idx increments; idx wraps DIGITS-1→0.
  - Frame period = DIGITS*SCAN_DIV cycles.
- Slot states per digit:
  - BLANK while cnt<BLANK: an all 1s, seg FF.
  - ON while cnt>=BLANK.
  - BLANK=0 means no blank state.
- Outputs are registered, one cycle behind the (cnt,idx) that selects them.
  - Example: the first ON cycle of digit k appears on an/seg the cycle after cnt==BLANK.
- ON drive for digit idx with nibble n=active.value[4*idx+:4]:
  - an[idx]=0, all other an bits 1.
  - seg[6:0] = decode(n)[6:0]; seg[7] = ~active.dp[idx].
- Leading-zero suppression: digit idx is suppressed when all of the following hold:
  - lzs=1;
  - idx!=0;
  - n==0 and every nibble above idx is 0.
- Drive for a suppressed digit:
  - dp[idx]=0: an all 1s, seg FF.
  - dp[idx]=1: an[idx]=0, seg=8'h7F (dp only).
  - Digit 0 is never suppressed (value 0 shows "0").
- Double buffer / handshake:
  - load=1 captures value and dp into staging in that cycle.
  - A later load overwrites staging (last write wins).
  - On the last cycle of the idx==DIGITS-1 slot: active←staging, and frame is asserted as a 1-cycle pulse on the following cycle.
  - A load in that same boundary cycle bypasses staging: active←value/dp directly, and staging is also updated.
  - active never changes mid-frame, so there is no tearing.
  - No ack is required; load may be held high, in which case active tracks value once per frame.
- Width rules: cnt is clog2(SCAN_DIV) bits wide; idx is clog2(DIGITS) bits wide, minimum 1.

Test Plan (DIGITS=4, SCAN_DIV=8, BLANK=2 unless stated):
- Reset: assert rst_n=0 during digit 2 ON → seg=FF and an=4'hF within the same cycle. After release, the first ON output is an=1110, seg=C0, 3 cycles after release (2 blank cycles plus 1 register cycle).
- Decode/scan: load value=16'h12A0, dp=0, lzs=0, then wait for frame. Each slot shows 2 blank cycles then 6 ON cycles:
  - an=1110, seg=C0
  - an=1101, seg=88
  - an=1011, seg=A4
  - an=0111, seg=F9
  - frame pulses exactly every 32 cycles.
- LZS: lzs=1, value=16'h0050:
  - digits 3 and 2 give an=F, seg=FF;
  - digit 1 gives seg=92;
  - digit 0 gives seg=C0.
  - With value=16'h0000, only digit 0 lights, seg=C0.
- DP: lzs=1, value=16'h0005, dp=4'b0010:
  - digit 1 gives an=1101, seg=7F;
  - digit 0 gives seg=92;
  - with lzs=0, digit 1 gives seg=40.
- Buffering: load 16'h1111 mid-frame, then 16'h2222 two cycles later → the current frame is unchanged; the next frame shows F9s never and A4 on all digits. A load of 16'h3333 exactly on the boundary cycle is displayed in the next frame.
- Extremes: BLANK=0, SCAN_DIV=2 → no blank cycles, an rotates every 2 cycles, frame period 8. Load value=16'hFFFF → seg=8E on every digit.
